// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - parametrised router packet-control FSM with drop and wait-timeout paths
//
// Steers one incoming packet stream to one of NUM_CH destination FIFOs and
// drives the load/parity/full control strobes for the register and
// synchroniser blocks.
//
// Ports:
//   clk            in   clock, all state updates on rising edge
//   reset          in   synchronous, active-high reset
//   data_in        in   [ADDR_W] header destination address (sampled in DECODE_ADDRESS)
//   pkt_valid      in   packet valid from source
//   fifo_full      in   selected destination FIFO full
//   fifo_empty     in   [NUM_CH] per-channel FIFO empty
//   soft_reset     in   [NUM_CH] per-channel soft reset (read timeout)
//   parity_done    in   parity byte already loaded
//   low_pkt_valid  in   pkt_valid fell while FIFO full
//   write_enb_reg  out  write enable towards FIFO
//   detect_add     out  in DECODE_ADDRESS
//   lfd_state      out  in LOAD_FIRST_DATA
//   ld_state       out  in LOAD_DATA
//   laf_state      out  in LOAD_AFTER_FULL
//   full_state     out  in FIFO_FULL_STATE
//   rst_int_reg    out  in CHECK_PARITY_ERROR
//   drop_state     out  in DROP_PACKET
//   busy           out  source must hold data
//   dest_addr      out  [ADDR_W] latched destination address
//   addr_err       out  one-cycle pulse: out-of-range address
//   wait_timeout   out  one-cycle pulse: wait-till-empty timeout

module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic              busy,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              addr_err,
  output logic              wait_timeout
);

  localparam logic [3:0] S_DECODE = 4'd0;
  localparam logic [3:0] S_LFD    = 4'd1;
  localparam logic [3:0] S_LD     = 4'd2;
  localparam logic [3:0] S_WAIT   = 4'd3;
  localparam logic [3:0] S_LP     = 4'd4;
  localparam logic [3:0] S_FULL   = 4'd5;
  localparam logic [3:0] S_LAF    = 4'd6;
  localparam logic [3:0] S_CPE    = 4'd7;
  localparam logic [3:0] S_DROP   = 4'd8;

  // Address space covered by data_in; the per-channel vectors are padded up
  // to this size so any address can index them without going out of range.
  localparam int NUM_SLOTS = 2 ** ADDR_W;

  // NUM_CH fits in ADDR_W+1 bits because NUM_CH <= 2**ADDR_W.
  localparam logic [ADDR_W:0] NUM_CH_EXT = NUM_CH[ADDR_W:0];

  localparam bit              TMO_EN     = (WAIT_TIMEOUT != 0);
  localparam int              TMO_LAST_I = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST  = TMO_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [3:0]          state_q, state_d;
  logic [ADDR_W-1:0]   dest_addr_q, dest_addr_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                addr_err_q, addr_err_d;
  logic                wait_timeout_q, wait_timeout_d;

  logic [NUM_SLOTS-1:0] empty_pad;
  logic [NUM_SLOTS-1:0] soft_pad;
  logic                 addr_in_range;
  logic                 dest_in_range;
  logic                 soft_hit;

  // Unused address slots read as "not empty" and "no soft reset".
  always_comb begin
    empty_pad               = '0;
    empty_pad[NUM_CH-1:0]   = fifo_empty;
    soft_pad                = '0;
    soft_pad[NUM_CH-1:0]    = soft_reset;
  end

  assign addr_in_range = ({1'b0, data_in}     < NUM_CH_EXT);
  assign dest_in_range = ({1'b0, dest_addr_q} < NUM_CH_EXT);

  // Only the channel currently being served can abort the packet.
  assign soft_hit = (state_q != S_DECODE) && dest_in_range && soft_pad[dest_addr_q];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DECODE: begin
        if (pkt_valid) begin
          if (!addr_in_range) begin
            state_d = S_DROP;
          end else if (empty_pad[data_in]) begin
            state_d = S_LFD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_LFD: begin
        state_d = S_LD;
      end
      S_LD: begin
        if (fifo_full) begin
          state_d = S_FULL;
        end else if (!pkt_valid) begin
          state_d = S_LP;
        end
      end
      S_WAIT: begin
        if (empty_pad[dest_addr_q]) begin
          state_d = S_LFD;
        end else if (TMO_EN && (wait_cnt_q == TMO_LAST)) begin
          state_d = S_DROP;
        end
      end
      S_LP: begin
        state_d = S_CPE;
      end
      S_FULL: begin
        if (!fifo_full) begin
          state_d = S_LAF;
        end
      end
      S_LAF: begin
        if (parity_done) begin
          state_d = S_DECODE;
        end else if (low_pkt_valid) begin
          state_d = S_LP;
        end else begin
          state_d = S_LD;
        end
      end
      S_CPE: begin
        if (fifo_full) begin
          state_d = S_FULL;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DROP: begin
        if (!pkt_valid) begin
          state_d = S_DECODE;
        end
      end
      default: begin
        state_d = S_DECODE;
      end
    endcase

    if (soft_hit) begin
      state_d = S_DECODE;
    end
  end

  // Address latch, wait counter and pulse generation
  always_comb begin
    dest_addr_d = dest_addr_q;
    if ((state_q == S_DECODE) && pkt_valid) begin
      dest_addr_d = data_in;
    end

    // Counter holds the number of cycles already spent in WAIT_TILL_EMPTY.
    wait_cnt_d = '0;
    if (state_q == S_WAIT) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
    end

    // Pulses are registered so they coincide with the first DROP_PACKET cycle.
    addr_err_d     = (state_q == S_DECODE) && (state_d == S_DROP);
    wait_timeout_d = (state_q == S_WAIT)   && (state_d == S_DROP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_DECODE;
      dest_addr_q    <= '0;
      wait_cnt_q     <= '0;
      addr_err_q     <= 1'b0;
      wait_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dest_addr_q    <= dest_addr_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_err_q     <= addr_err_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  // Moore outputs
  assign detect_add    = (state_q == S_DECODE);
  assign lfd_state     = (state_q == S_LFD);
  assign ld_state      = (state_q == S_LD);
  assign laf_state     = (state_q == S_LAF);
  assign full_state    = (state_q == S_FULL);
  assign rst_int_reg   = (state_q == S_CPE);
  assign drop_state    = (state_q == S_DROP);

  assign busy          = (state_q == S_LFD)  || (state_q == S_LP)  ||
                         (state_q == S_FULL) || (state_q == S_LAF) ||
                         (state_q == S_WAIT) || (state_q == S_CPE);

  assign write_enb_reg = (state_q == S_LD) || (state_q == S_LP) || (state_q == S_LAF);

  assign dest_addr     = dest_addr_q;
  assign addr_err      = addr_err_q;
  assign wait_timeout  = wait_timeout_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb/tb_router_fsm_nch.sv - self-checking bench for router_fsm_nch against a behavioural model

module tb_router_fsm_nch;

  localparam int NUM_CH       = 3;
  localparam int ADDR_W       = 2;
  localparam int WAIT_TIMEOUT = 16;
  localparam int CNT_W        = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] data_in;
  logic              pkt_valid;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              write_enb_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              drop_state;
  logic              busy;
  logic [ADDR_W-1:0] dest_addr;
  logic              addr_err;
  logic              wait_timeout;

  router_fsm_nch #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .drop_state(drop_state), .busy(busy),
    .dest_addr(dest_addr), .addr_err(addr_err), .wait_timeout(wait_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference model: named phases of a packet, a plain integer
  // count of cycles spent waiting, and the pulse flags.
  typedef enum {M_DEC, M_LFD, M_LD, M_WAIT, M_LP, M_FULL, M_LAF, M_CPE, M_DROP} phase_t;
  phase_t m_st;
  int     m_dest;
  int     m_waited;
  bit     m_aerr;
  bit     m_tmo;

  task automatic model_step();
    phase_t nxt;
    int     a;
    if (reset) begin
      m_st = M_DEC; m_dest = 0; m_waited = 0; m_aerr = 0; m_tmo = 0;
      return;
    end
    a   = int'(data_in);
    nxt = m_st;
    case (m_st)
      M_DEC:  if (pkt_valid) nxt = (a >= NUM_CH) ? M_DROP : (fifo_empty[a] ? M_LFD : M_WAIT);
      M_LFD:  nxt = M_LD;
      M_LD:   nxt = fifo_full ? M_FULL : (!pkt_valid ? M_LP : M_LD);
      M_WAIT: if (fifo_empty[m_dest]) nxt = M_LFD;
              else if (WAIT_TIMEOUT != 0 && m_waited == WAIT_TIMEOUT - 1) nxt = M_DROP;
      M_LP:   nxt = M_CPE;
      M_FULL: nxt = fifo_full ? M_FULL : M_LAF;
      M_LAF:  nxt = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
      M_CPE:  nxt = fifo_full ? M_FULL : M_DEC;
      M_DROP: nxt = pkt_valid ? M_DROP : M_DEC;
      default: nxt = M_DEC;
    endcase
    if (m_st != M_DEC && m_dest < NUM_CH && soft_reset[m_dest]) nxt = M_DEC;
    m_aerr   = (m_st == M_DEC)  && (nxt == M_DROP);
    m_tmo    = (m_st == M_WAIT) && (nxt == M_DROP);
    m_waited = (m_st == M_WAIT) ? ((m_waited + 1 > 255) ? 255 : m_waited + 1) : 0;
    if (m_st == M_DEC && pkt_valid) m_dest = a;
    m_st = nxt;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("detect_add",    32'(detect_add),    32'(m_st == M_DEC));
    chk("lfd_state",     32'(lfd_state),     32'(m_st == M_LFD));
    chk("ld_state",      32'(ld_state),      32'(m_st == M_LD));
    chk("laf_state",     32'(laf_state),     32'(m_st == M_LAF));
    chk("full_state",    32'(full_state),    32'(m_st == M_FULL));
    chk("rst_int_reg",   32'(rst_int_reg),   32'(m_st == M_CPE));
    chk("drop_state",    32'(drop_state),    32'(m_st == M_DROP));
    chk("busy",          32'(busy),
        32'(m_st inside {M_LFD, M_LP, M_FULL, M_LAF, M_WAIT, M_CPE}));
    chk("write_enb_reg", 32'(write_enb_reg), 32'(m_st inside {M_LD, M_LP, M_LAF}));
    chk("dest_addr",     32'(dest_addr),     32'(m_dest));
    chk("addr_err",      32'(addr_err),      32'(m_aerr));
    chk("wait_timeout",  32'(wait_timeout),  32'(m_tmo));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    reset = 1'b1; data_in = '0; pkt_valid = 1'b0; fifo_full = 1'b0;
    fifo_empty = '1; soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    m_st = M_DEC; m_dest = 0; m_waited = 0; m_aerr = 0; m_tmo = 0;
    step(); step();
    reset = 1'b0;
    step();

    // 1: normal packet to channel 1
    data_in = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b111;
    repeat (4) step();
    pkt_valid = 1'b0;
    repeat (4) step();

    // 2: channel 2 busy for five cycles, then frees up
    data_in = 2'd2; pkt_valid = 1'b1; fifo_empty = 3'b011;
    repeat (5) step();
    fifo_empty = 3'b111;
    step(); step();
    pkt_valid = 1'b0;
    repeat (4) step();

    // 3: out-of-range address dropped while pkt_valid held
    data_in = 2'd3; pkt_valid = 1'b1;
    repeat (6) step();
    pkt_valid = 1'b0;
    step(); step();

    // 4: channel 0 never drains -> timeout after exactly WAIT_TIMEOUT cycles
    data_in = 2'd0; pkt_valid = 1'b1; fifo_empty = 3'b110;
    step();
    cnt = 0;
    for (int i = 0; i < 40 && !drop_state; i++) begin
      if (busy) cnt++;
      step();
    end
    chk("t4_wait_cycles", 32'(cnt), 32'(WAIT_TIMEOUT));
    chk("t4_timeout_pulse", 32'(wait_timeout), 32'd1);
    pkt_valid = 1'b0; fifo_empty = 3'b111;
    step(); step();

    // 5: full handling, LAF exits via low_pkt_valid and via parity_done
    data_in = 2'd1; pkt_valid = 1'b1;
    repeat (3) step();
    fifo_full = 1'b1;
    repeat (3) step();
    fifo_full = 1'b0;
    step();
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step();
    low_pkt_valid = 1'b0;
    repeat (3) step();
    pkt_valid = 1'b1;
    repeat (3) step();
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    step();
    parity_done = 1'b1; pkt_valid = 1'b0;
    step();
    parity_done = 1'b0;
    step();

    // 6: soft reset of other channel ignored, own channel aborts; reset in FULL
    data_in = 2'd1; pkt_valid = 1'b1;
    repeat (3) step();
    soft_reset = 3'b001;
    step();
    soft_reset = 3'b010;
    step();
    soft_reset = 3'b000;
    repeat (3) step();
    fifo_full = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
    step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      data_in       = ADDR_W'($urandom_range(0, 3));
      pkt_valid     = ($urandom_range(0, 3) != 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty    = NUM_CH'($urandom_range(0, 7));
      soft_reset    = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom_range(1, 7)) : '0;
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the router packet-control FSM. It steers one incoming packet stream to one of NUM_CH destination FIFOs. It drives the load/parity/full control strobes to the register and synchroniser blocks. New over the fixed 3-channel controller: parametrised channel count and address width, vectorised FIFO-empty and soft-reset inputs, a DROP_PACKET path for out-of-range addresses, and a bounded wait-till-empty timeout.

Parameters:
NUM_CH, 3, number of destination FIFOs; must satisfy 1 <= NUM_CH <= 2**ADDR_W
ADDR_W, 2, width of the header address field (data_in)
WAIT_TIMEOUT, 16, maximum cycles spent in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout
CNT_W, 8, width of the wait counter; WAIT_TIMEOUT must be < 2**CNT_W

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  ADDR_W  header destination address, sampled in DECODE_ADDRESS
pkt_valid  in  1  packet valid from source
fifo_full  in  1  selected destination FIFO full (from synchroniser)
fifo_empty  in  NUM_CH  per-channel FIFO empty
soft_reset  in  NUM_CH  per-channel soft reset (read-timeout from synchroniser)
parity_done  in  1  parity byte already loaded (from register block)
low_pkt_valid  in  1  pkt_valid fell while FIFO full (from register block)
write_enb_reg  out  1  write enable towards FIFO
detect_add  out  1  FSM in DECODE_ADDRESS
lfd_state  out  1  FSM in LOAD_FIRST_DATA
ld_state  out  1  FSM in LOAD_DATA
laf_state  out  1  FSM in LOAD_AFTER_FULL
full_state  out  1  FSM in FIFO_FULL_STATE
rst_int_reg  out  1  FSM in CHECK_PARITY_ERROR
drop_state  out  1  FSM in DROP_PACKET
busy  out  1  source must hold data
dest_addr  out  ADDR_W  latched destination address
addr_err  out  1  one-cycle pulse: out-of-range address
wait_timeout  out  1  one-cycle pulse: wait-till-empty timeout

Behaviour:
- Reset state: DECODE_ADDRESS; dest_addr=0; wait counter=0; addr_err=wait_timeout=0. After reset detect_add=1 and all other outputs are 0.
- 4-bit state register with 9 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET. Unused encodings go to DECODE_ADDRESS next cycle.
- dest_addr loads data_in when state=DECODE_ADDRESS and pkt_valid=1. Otherwise it holds.
- "valid" means data_in < NUM_CH. "empty_sel" means fifo_empty[dest_addr].
- Transitions (priority top-down):
  - DECODE_ADDRESS:
    - pkt_valid and data_in >= NUM_CH -> DROP_PACKET.
    - pkt_valid, valid, fifo_empty[data_in] -> LOAD_FIRST_DATA.
    - pkt_valid, valid, !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
    - else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - !pkt_valid -> LOAD_PARITY.
    - else stay.
  - WAIT_TILL_EMPTY:
    - empty_sel -> LOAD_FIRST_DATA.
    - WAIT_TIMEOUT != 0 and counter == WAIT_TIMEOUT-1 -> DROP_PACKET.
    - else stay.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - FIFO_FULL_STATE:
    - fifo_full -> stay.
    - else -> LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - CHECK_PARITY_ERROR:
    - fifo_full -> FIFO_FULL_STATE.
    - else -> DECODE_ADDRESS.
  - DROP_PACKET:
    - pkt_valid -> stay.
    - else -> DECODE_ADDRESS.
- Soft reset: if state != DECODE_ADDRESS, dest_addr < NUM_CH and soft_reset[dest_addr]=1, next state = DECODE_ADDRESS. This overrides all transitions except reset. Soft reset of any other channel has no effect.
- Wait counter: cleared in every state other than WAIT_TILL_EMPTY. It increments by 1 each cycle in WAIT_TILL_EMPTY and saturates at 2**CNT_W-1.
- Pulses (registered, high for exactly one cycle, the first cycle in DROP_PACKET):
  - addr_err when DROP_PACKET was entered from DECODE_ADDRESS.
  - wait_timeout when DROP_PACKET was entered from WAIT_TILL_EMPTY.
- Moore outputs decoded from state only:
  - busy=1 in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
  - busy=0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
  - write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL. It is never 1 in DROP_PACKET.
- Reset mid-packet returns to DECODE_ADDRESS on the next edge and clears all pulses and counters.

Test Plan:
1. reset, then pkt_valid=1, data_in=1, fifo_empty=3'b111, pkt_valid held 4 cycles then 0 -> required sequence DECODE, LFD, LD x3, LOAD_PARITY, CPE, DECODE; dest_addr=1; write_enb_reg high only in LD/LP.
2. data_in=2, fifo_empty[2]=0 for 5 cycles then 1 -> 5 cycles in WAIT_TILL_EMPTY with busy=1, then LFD; wait_timeout stays 0.
3. data_in=3 with NUM_CH=3 and pkt_valid held 6 cycles -> DROP_PACKET for 6 cycles; addr_err high for exactly the first cycle; busy=0 and write_enb_reg=0 throughout; then DECODE.
4. data_in=0, fifo_empty[0] held 0 -> DROP_PACKET entered after exactly 16 WAIT cycles; wait_timeout pulses for 1 cycle.
5. In LOAD_DATA, fifo_full=1 for 3 cycles -> FIFO_FULL_STATE x3, then LAF. In LAF: low_pkt_valid=1 -> LOAD_PARITY; parity_done=1 -> DECODE.
6. dest_addr=1 in LOAD_DATA: soft_reset=3'b001 -> no effect; soft_reset=3'b010 -> DECODE next cycle. Assert reset during FIFO_FULL_STATE -> DECODE with detect_add=1 next cycle.
